// File: rtl/uart_pkg.sv
// Shared UART definitions: frame parity selection, receiver FSM states and
// the baud divider calculation used by the RX path and the future TX path.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_t;

  typedef enum logic [2:0] {
    RX_IDLE      = 3'd0,
    RX_START     = 3'd1,
    RX_DATA      = 3'd2,
    RX_PARITY    = 3'd3,
    RX_STOP      = 3'd4,
    RX_WAIT_HIGH = 3'd5
  } rx_state_t;

  // round(clk / (baud*os)), never below 1
  function automatic int unsigned uart_div(input longint unsigned clk_hz,
                                           input longint unsigned baud,
                                           input longint unsigned os);
    longint unsigned den;
    longint unsigned q;
    den = baud * os;
    q   = (clk_hz + den / 64'd2) / den;
    if (q < 64'd1) q = 64'd1;
    return 32'(q);
  endfunction

endpackage

// File: rtl/uart_rx_os_if.sv
// Receive-word handshake between the UART receiver and its consumer,
// plus the receiver's status strobes.
interface uart_rx_os_if #(
  parameter int unsigned DATA_BITS = 8
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 break_det;
  logic                 overrun;
  logic                 busy;

  modport master (
    output rx_data, rx_valid, parity_err, frame_err, break_det, overrun, busy,
    input  rx_ready
  );

  modport slave (
    input  rx_data, rx_valid, parity_err, frame_err, break_det, overrun, busy,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle strobe every DIV clocks, with a
// synchronous restart so the tick phase can be aligned to an external event.
module uart_baud_tick #(
  parameter int unsigned DIV = 4
) (
  input  logic clock,
  input  logic rst_n,
  input  logic restart,
  output logic tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (restart) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: 3-sample majority vote per bit, configurable
// frame, one-word output buffer with framing/parity/break/overrun reporting.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned DATA_BITS  = 8,
  parameter parity_t     PARITY     = PAR_NONE,
  parameter int unsigned STOP_BITS  = 1,
  parameter bit          MSB_FIRST  = 1'b0
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         rx,
  uart_rx_os_if.master bus
);

  localparam int unsigned DIV = uart_div(64'(CLK_FREQ), 64'(BAUD), 64'(OVERSAMPLE));
  localparam int unsigned SCW = $clog2(OVERSAMPLE);
  localparam int unsigned BCW = 4;
  // s_cnt holds ticks elapsed in the bit minus one, so these hit ticks OS/2-1..OS/2+1
  localparam int unsigned SAMP_A = OVERSAMPLE / 2 - 2;
  localparam int unsigned SAMP_B = OVERSAMPLE / 2 - 1;
  localparam int unsigned SAMP_C = OVERSAMPLE / 2;

  rx_state_t state, state_n;

  logic                 rx_m, rx_s;
  logic                 tick;
  logic [SCW-1:0]       s_cnt;
  logic [BCW-1:0]       bit_cnt;
  logic                 samp_a, samp_b;
  logic [DATA_BITS-1:0] data_sr;
  logic                 pbit_r;
  logic                 fe_acc;

  logic [DATA_BITS-1:0] rx_data_r;
  logic                 rx_valid_r, parity_err_r, frame_err_r;
  logic                 break_r, overrun_r, busy_r;

  logic maj_c, decide_c, bit_end_c, pe_c, fe_c;
  logic restart_c, shift_c, pbit_c, stop_low_c, bit_inc_c, bit_clr_c;
  logic deliver_c, brk_c;

  // Two-flop synchroniser, idles high
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clock   (clock),
    .rst_n   (rst_n),
    .restart (restart_c),
    .tick    (tick)
  );

  assign maj_c     = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign decide_c  = tick && (s_cnt == SCW'(SAMP_C));
  assign bit_end_c = tick && (s_cnt == SCW'(OVERSAMPLE - 1));
  assign pe_c      = (PARITY != PAR_NONE) && ((^data_sr ^ pbit_r) != (PARITY == PAR_ODD));
  assign fe_c      = fe_acc | ~maj_c;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= RX_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    restart_c  = 1'b0;
    shift_c    = 1'b0;
    pbit_c     = 1'b0;
    stop_low_c = 1'b0;
    bit_inc_c  = 1'b0;
    bit_clr_c  = 1'b0;
    deliver_c  = 1'b0;
    brk_c      = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_s) begin
          state_n   = RX_START;
          restart_c = 1'b1;
        end
      end
      RX_START: begin
        if (decide_c && maj_c) state_n = RX_IDLE;
        else if (bit_end_c)    state_n = RX_DATA;
      end
      RX_DATA: begin
        shift_c = decide_c;
        if (bit_end_c) begin
          if (bit_cnt == BCW'(DATA_BITS - 1)) begin
            bit_clr_c = 1'b1;
            state_n   = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
          end else begin
            bit_inc_c = 1'b1;
          end
        end
      end
      RX_PARITY: begin
        pbit_c = decide_c;
        if (bit_end_c) state_n = RX_STOP;
      end
      RX_STOP: begin
        if (decide_c) begin
          stop_low_c = ~maj_c;
          // Last stop bit completes at its centre for half-bit resync margin
          if (bit_cnt == BCW'(STOP_BITS - 1)) begin
            if (!maj_c && (data_sr == '0) && ((PARITY == PAR_NONE) || !pbit_r)) begin
              brk_c   = 1'b1;
              state_n = RX_WAIT_HIGH;
            end else begin
              deliver_c = 1'b1;
              state_n   = maj_c ? RX_IDLE : RX_WAIT_HIGH;
            end
          end
        end else if (bit_end_c) begin
          bit_inc_c = 1'b1;
        end
      end
      RX_WAIT_HIGH: begin
        if (rx_s) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  // Sample/bit counters, vote samples and frame assembly
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      s_cnt   <= '0;
      bit_cnt <= '0;
      samp_a  <= 1'b1;
      samp_b  <= 1'b1;
      data_sr <= '0;
      pbit_r  <= 1'b0;
      fe_acc  <= 1'b0;
    end else begin
      if (restart_c) begin
        s_cnt   <= '0;
        bit_cnt <= '0;
        fe_acc  <= 1'b0;
      end else begin
        if (tick) s_cnt <= (s_cnt == SCW'(OVERSAMPLE - 1)) ? '0 : s_cnt + 1'b1;
        if (bit_clr_c)      bit_cnt <= '0;
        else if (bit_inc_c) bit_cnt <= bit_cnt + 1'b1;
        if (stop_low_c) fe_acc <= 1'b1;
      end
      if (tick && (s_cnt == SCW'(SAMP_A))) samp_a <= rx_s;
      if (tick && (s_cnt == SCW'(SAMP_B))) samp_b <= rx_s;
      if (shift_c) begin
        data_sr <= MSB_FIRST ? {data_sr[DATA_BITS-2:0], maj_c}
                             : {maj_c, data_sr[DATA_BITS-1:1]};
      end
      if (pbit_c) pbit_r <= maj_c;
    end
  end

  // One-word output buffer; a full buffer keeps the old word and flags overrun
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_data_r    <= '0;
      rx_valid_r   <= 1'b0;
      parity_err_r <= 1'b0;
      frame_err_r  <= 1'b0;
      break_r      <= 1'b0;
      overrun_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      break_r   <= brk_c;
      overrun_r <= 1'b0;
      busy_r    <= (state_n != RX_IDLE);
      if (rx_valid_r && bus.rx_ready) rx_valid_r <= 1'b0;
      if (deliver_c) begin
        if (!rx_valid_r || bus.rx_ready) begin
          rx_data_r    <= data_sr;
          parity_err_r <= pe_c;
          frame_err_r  <= fe_c;
          rx_valid_r   <= 1'b1;
        end else begin
          overrun_r <= 1'b1;
        end
      end
    end
  end

  assign bus.rx_data    = rx_data_r;
  assign bus.rx_valid   = rx_valid_r;
  assign bus.parity_err = parity_err_r;
  assign bus.frame_err  = frame_err_r;
  assign bus.break_det  = break_r;
  assign bus.overrun    = overrun_r;
  assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx_os.sv
// Directed bench for uart_rx_os: an 8N1 and an 8E1 receiver at 64 clocks/bit,
// hand-computed expectations checked with immediate assertions.
module tb_uart_rx_os;
  import uart_pkg::*;

  localparam int unsigned BIT_CLK = 64;
  // 2 + (1+8+0+1-0.5)*64 + 1; the third vote sample and registered tick add up to DIV+2
  localparam int unsigned LAT_F   = 611;

  logic clock = 1'b0;
  logic rst_n = 1'b0;
  logic line  = 1'b1;
  logic sel_e = 1'b0;
  logic ready_n = 1'b1;
  logic ready_e = 1'b1;
  logic rx_n, rx_e;

  always #5 clock = ~clock;

  assign rx_n = sel_e ? 1'b1 : line;
  assign rx_e = sel_e ? line : 1'b1;

  uart_rx_os_if #(.DATA_BITS(8)) bn ();
  uart_rx_os_if #(.DATA_BITS(8)) be ();
  assign bn.rx_ready = ready_n;
  assign be.rx_ready = ready_e;

  uart_rx_os #(
    .CLK_FREQ(7_372_800), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(PAR_NONE), .STOP_BITS(1), .MSB_FIRST(1'b0)
  ) dut_n (.clock(clock), .rst_n(rst_n), .rx(rx_n), .bus(bn.master));

  uart_rx_os #(
    .CLK_FREQ(7_372_800), .BAUD(115200), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(PAR_EVEN), .STOP_BITS(1), .MSB_FIRST(1'b0)
  ) dut_e (.clock(clock), .rst_n(rst_n), .rx(rx_e), .bus(be.master));

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Event monitors, sampled on the inactive edge
  int unsigned vrise_n = 0, vhi_n = 0, brk_n = 0, ovr_n = 0, rise_cyc_n = 0;
  int unsigned vrise_e = 0;
  logic        prev_v_n = 1'b0, prev_v_e = 1'b0;
  logic [7:0]  cap_d_n = 8'h00, cap_d_e = 8'h00;
  logic        cap_pe_n = 1'b0, cap_fe_n = 1'b0, cap_pe_e = 1'b0, cap_fe_e = 1'b0;

  always @(negedge clock) begin
    prev_v_n <= bn.rx_valid;
    prev_v_e <= be.rx_valid;
    if (bn.rx_valid) vhi_n <= vhi_n + 1;
    if (bn.break_det) brk_n <= brk_n + 1;
    if (bn.overrun)   ovr_n <= ovr_n + 1;
    if (bn.rx_valid && !prev_v_n) begin
      vrise_n    <= vrise_n + 1;
      rise_cyc_n <= cyc;
      cap_d_n    <= bn.rx_data;
      cap_pe_n   <= bn.parity_err;
      cap_fe_n   <= bn.frame_err;
    end
    if (be.rx_valid && !prev_v_e) begin
      vrise_e  <= vrise_e + 1;
      cap_d_e  <= be.rx_data;
      cap_pe_e <= be.parity_err;
      cap_fe_e <= be.frame_err;
    end
  end

  int unsigned total = 0;
  int unsigned bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic v, input int unsigned n);
    line = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input bit par_en, input logic pbit, input logic stop_v);
    hold(1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) hold(d[i], BIT_CLK);
    if (par_en) hold(pbit, BIT_CLK);
    hold(stop_v, BIT_CLK);
    hold(1'b1, 2 * BIT_CLK);
  endtask

  int unsigned t0, v0, h0, b0, o0, lat;

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_valid",   32'(bn.rx_valid),   32'd0);
    chk("rst_busy",    32'(bn.busy),       32'd0);
    chk("rst_data",    32'(bn.rx_data),    32'd0);
    chk("rst_flags",   32'({bn.parity_err, bn.frame_err, bn.break_det, bn.overrun}), 32'd0);
    rst_n = 1'b1;
    hold(1'b1, 2 * BIT_CLK);

    // 1: 8N1 0xA5, consumer ready
    v0 = vrise_n; h0 = vhi_n; t0 = cyc;
    send(8'hA5, 1'b0, 1'b0, 1'b1);
    lat = rise_cyc_n - t0;
    chk("t1_rises",    32'(vrise_n - v0), 32'd1);
    chk("t1_hi_cyc",   32'(vhi_n - h0),   32'd1);
    chk("t1_data",     32'(cap_d_n),      32'hA5);
    chk("t1_pe",       32'(cap_pe_n),     32'd0);
    chk("t1_fe",       32'(cap_fe_n),     32'd0);
    chk("t1_latency",  32'((lat >= LAT_F) && (lat <= LAT_F + 6)), 32'd1);
    chk("t1_idle",     32'(bn.busy),      32'd0);

    // 2: 8E1 0x03, wrong then right parity bit
    sel_e = 1'b1;
    v0 = vrise_e;
    send(8'h03, 1'b1, 1'b1, 1'b1);
    chk("t2a_data",    32'(cap_d_e),  32'h03);
    chk("t2a_pe",      32'(cap_pe_e), 32'd1);
    chk("t2a_fe",      32'(cap_fe_e), 32'd0);
    send(8'h03, 1'b1, 1'b0, 1'b1);
    chk("t2b_data",    32'(cap_d_e),  32'h03);
    chk("t2b_pe",      32'(cap_pe_e), 32'd0);
    chk("t2_rises",    32'(vrise_e - v0), 32'd2);
    sel_e = 1'b0;

    // 3: overrun with consumer stalled
    ready_n = 1'b0;
    v0 = vrise_n; o0 = ovr_n;
    send(8'h11, 1'b0, 1'b0, 1'b1);
    send(8'h22, 1'b0, 1'b0, 1'b1);
    chk("t3_valid",    32'(bn.rx_valid),  32'd1);
    chk("t3_data",     32'(bn.rx_data),   32'h11);
    chk("t3_fe",       32'(bn.frame_err), 32'd0);
    chk("t3_overrun",  32'(ovr_n - o0),   32'd1);
    chk("t3_rises",    32'(vrise_n - v0), 32'd1);
    ready_n = 1'b1;
    @(posedge clock);
    #1;
    chk("t3_drop",     32'(bn.rx_valid),  32'd0);

    // 4: 12 bit-times of break, then a normal frame
    v0 = vrise_n; b0 = brk_n;
    hold(1'b0, 12 * BIT_CLK);
    chk("t4_break",    32'(brk_n - b0),   32'd1);
    chk("t4_novalid",  32'(vrise_n - v0), 32'd0);
    chk("t4_waithigh", 32'(bn.busy),      32'd1);
    hold(1'b1, 2 * BIT_CLK);
    chk("t4_idle",     32'(bn.busy),      32'd0);
    send(8'h5A, 1'b0, 1'b0, 1'b1);
    chk("t4_data",     32'(cap_d_n),      32'h5A);
    chk("t4_fe",       32'(cap_fe_n),     32'd0);
    chk("t4_rises",    32'(vrise_n - v0), 32'd1);

    // 5: 20-clock glitch on idle line
    v0 = vrise_n; b0 = brk_n; o0 = ovr_n;
    hold(1'b0, 20);
    chk("t5_start",    32'(bn.busy),      32'd1);
    hold(1'b1, 2 * BIT_CLK);
    chk("t5_idle",     32'(bn.busy),      32'd0);
    chk("t5_novalid",  32'(vrise_n - v0), 32'd0);
    chk("t5_noflags",  32'((brk_n - b0) + (ovr_n - o0)), 32'd0);

    // 6: reset during data bit 4 of 0x3C
    hold(1'b0, BIT_CLK);
    hold(1'b0, BIT_CLK);
    hold(1'b0, BIT_CLK);
    hold(1'b1, BIT_CLK);
    hold(1'b1, BIT_CLK);
    hold(1'b1, 20);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bn.rx_valid), 32'd0);
    chk("t6_rst_busy",  32'(bn.busy),     32'd0);
    chk("t6_rst_data",  32'(bn.rx_data),  32'd0);
    repeat (4) @(posedge clock);
    #1;
    rst_n = 1'b1;
    hold(1'b1, BIT_CLK);
    v0 = vrise_n; b0 = brk_n;
    send(8'h3C, 1'b0, 1'b0, 1'b1);
    chk("t6_data",     32'(cap_d_n),      32'h3C);
    chk("t6_fe",       32'(cap_fe_n),     32'd0);
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    chk("t6_fe_data",  32'(cap_d_n),      32'h3C);
    chk("t6_fe_flag",  32'(cap_fe_n),     32'd1);
    chk("t6_rises",    32'(vrise_n - v0), 32'd2);
    chk("t6_nobreak",  32'(brk_n - b0),   32'd0);
    chk("t6_idle",     32'(bn.busy),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
